// File: rtl/io_port_ctrl.sv
// io_port_ctrl: CPU-side I/O port block.
// Holds NUM_OUT output registers and synchronises NUM_IN input ports.
// External interrupt lines are synchronised, edge-detected, latched in a
// pending register, masked, and presented to the CPU as a registered level.
// Optional feature macro: OUT_READBACK_EN. When defined, OUT-range reads
// return the current output register, so the CPU can read-modify-write.
module io_port_ctrl #(
  parameter int unsigned NUM_OUT       = 4,
  parameter int unsigned NUM_IN        = 4,
  parameter int unsigned NUM_IRQ       = 4,
  parameter logic [7:0]  OUT_BASE      = 8'h40,
  parameter logic [7:0]  IN_BASE       = 8'h20,
  parameter logic [7:0]  IRQ_MASK_ADDR = 8'hF0,
  parameter logic [7:0]  IRQ_PEND_ADDR = 8'hF1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             port_id,
  input  logic [7:0]             out_port,
  input  logic                   io_strb,
  output logic [7:0]             in_port,
  output logic [8*NUM_OUT-1:0]   gpio_out,
  input  logic [8*NUM_IN-1:0]    gpio_in,
  input  logic [NUM_IRQ-1:0]     irq_in,
  output logic                   interrupt,
  output logic [NUM_IRQ-1:0]     irq_pending
);

  // 9-bit range bounds so base+N up to 256 is representable
  localparam logic [8:0] OUT_LO = {1'b0, OUT_BASE};
  localparam logic [8:0] OUT_HI = OUT_LO + 9'(NUM_OUT);
  localparam logic [8:0] IN_LO  = {1'b0, IN_BASE};
  localparam logic [8:0] IN_HI  = IN_LO + 9'(NUM_IN);
  localparam logic [8:0] MSK9   = {1'b0, IRQ_MASK_ADDR};
  localparam logic [8:0] PND9   = {1'b0, IRQ_PEND_ADDR};

  if (NUM_OUT < 1 || NUM_OUT > 8 || NUM_IN < 1 || NUM_IN > 8 ||
      NUM_IRQ < 1 || NUM_IRQ > 8) begin : g_bad_count
    $error("io_port_ctrl: port/irq counts must be 1..8");
  end
  if (OUT_HI > 9'd256 || IN_HI > 9'd256) begin : g_bad_range
    $error("io_port_ctrl: address range exceeds 8-bit port space");
  end
  if ((OUT_LO < IN_HI && IN_LO < OUT_HI) ||
      (MSK9 >= OUT_LO && MSK9 < OUT_HI) || (MSK9 >= IN_LO && MSK9 < IN_HI) ||
      (PND9 >= OUT_LO && PND9 < OUT_HI) || (PND9 >= IN_LO && PND9 < IN_HI) ||
      (MSK9 == PND9)) begin : g_bad_overlap
    $error("io_port_ctrl: overlapping address decode");
  end

  logic [8:0]             pid9;
  logic [8*NUM_OUT-1:0]   out_q, out_d;
  logic [8*NUM_IN-1:0]    gin_s1_q, gin_s2_q;
  logic [NUM_IRQ-1:0]     irq_s1_q, irq_s2_q, irq_prev_q;
  logic [NUM_IRQ-1:0]     mask_q, mask_d;
  logic [NUM_IRQ-1:0]     pend_q, pend_d;
  logic [NUM_IRQ-1:0]     rise, clr;
  logic                   int_q;
  logic [7:0]             mask_ext, pend_ext, rd;

  assign pid9 = {1'b0, port_id};
  assign rise = irq_s2_q & ~irq_prev_q;

  // CPU write decode; a rising edge sets pending even if cleared in the same cycle
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    clr    = '0;
    if (io_strb) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (pid9 == OUT_LO + 9'(k)) out_d[8*k +: 8] = out_port;
      end
      if (port_id == IRQ_MASK_ADDR) mask_d = out_port[NUM_IRQ-1:0];
      if (port_id == IRQ_PEND_ADDR) clr    = out_port[NUM_IRQ-1:0];
    end
    pend_d = (pend_q & ~clr) | rise;
  end

  // Register state: outputs, mask, pending, synchronisers, interrupt level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= '0;
      mask_q     <= '0;
      pend_q     <= '0;
      gin_s1_q   <= '0;
      gin_s2_q   <= '0;
      irq_s1_q   <= '0;
      irq_s2_q   <= '0;
      irq_prev_q <= '0;
      int_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      gin_s1_q   <= gin_in_w();
      gin_s2_q   <= gin_s1_q;
      irq_s1_q   <= irq_in;
      irq_s2_q   <= irq_s1_q;
      irq_prev_q <= irq_s2_q;
      int_q      <= |(pend_q & mask_q);
    end
  end

  function automatic logic [8*NUM_IN-1:0] gin_in_w();
    return gpio_in;
  endfunction

  // Read mux, combinational from port_id; pending outranks mask outranks ranges
  always_comb begin
    mask_ext = '0;
    pend_ext = '0;
    mask_ext[NUM_IRQ-1:0] = mask_q;
    pend_ext[NUM_IRQ-1:0] = pend_q;
    rd = '0;
    if (port_id == IRQ_PEND_ADDR) begin
      rd = pend_ext;
    end else if (port_id == IRQ_MASK_ADDR) begin
      rd = mask_ext;
    end else begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        if (pid9 == IN_LO + 9'(k)) rd = gin_s2_q[8*k +: 8];
      end
`ifdef OUT_READBACK_EN
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (pid9 == OUT_LO + 9'(k)) rd = out_q[8*k +: 8];
      end
`else
`endif
    end
  end

  assign in_port     = rd;
  assign gpio_out    = out_q;
  assign interrupt   = int_q;
  assign irq_pending = pend_q;

endmodule
